pipelined_add_sub: RTL
======================

// Module: pipelined_add_sub
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor. Next generation of the 4-bit ripple adder.
//   The WIDTH-bit carry chain is cut into STAGES slices with one register boundary per slice.
//   Ripple depth per cycle is WIDTH/STAGES; throughput is one operation per clock.
//   Valid/ready handshakes on both sides; stalls are per stage and fill bubbles.
//   Sits between operand sources and the ALU result bus of the lab datapath.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline stages (>=1); slice width SW = WIDTH/STAGES
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand word valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: A+B+cin   1: A-B-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry-out (sub: 1 = no borrow)
//   ovf        out  1      signed overflow of the operation
// BEHAVIOUR
//   - Transfer on a port occurs when valid & ready are both high at a rising edge.
//   - Reset (rst_n=0, async): all stage valid bits = 0, all data registers = 0.
//     Outputs during and after reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
//     Reset mid-operation discards every in-flight op; no result for it ever appears.
//   - Datapath: B' = sub ? ~b : b; c0 = sub ? ~cin : cin.
//     Stage k adds slice k of A and B' plus the carry registered by stage k-1.
//   - Slice 0 is computed in the input stage; remaining A/B' slices travel with the op.
//   - Latency: with no backpressure, an op accepted at edge N shows out_valid=1 after edge N+STAGES-1.
//   - Stage ready: rdy[k] = !vld[k] | rdy[k+1]; rdy[STAGES-1] = !out_valid | out_ready.
//     in_ready = rdy[0] (combinational; no combinational path from in_valid to in_ready).
//   - A stage holds its contents while !rdy[k]. Ops never reorder, drop or duplicate.
//   - cout = carry out of the MSB slice.
//     ovf = (a[W-1] == B'[W-1]) & (raw_sum[W-1] != a[W-1]).
//   - STAGES=1: combinational add into one output register, same handshake rules.
//   - Simultaneous accept at input and drain at output with the pipe full is legal: occupancy is unchanged.
//   - out_valid, sum, cout and ovf are stable while out_valid & !out_ready.
// CONFIGURATION
//   ADDER_SAT_EN defined:
//     when ovf=1, sum is clamped to the signed limit:
//       positive overflow -> {0,1..1}
//       negative overflow -> {1,0..0}
//     ovf is still reported and cout is unchanged.
//     The clamp is applied in the last stage and adds no latency.
//   ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH; no clamp logic is present.
// TESTING (WIDTH=16, STAGES=4, out_ready=1 unless stated)
//   1. Hold rst_n=0 -> out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
//      Release, then assert rst_n=0 mid-stream -> out_valid drops immediately, no stale results afterwards.
//   2. a=0x00FF b=0x0001 cin=0 sub=0 -> after 4 edges sum=0x0100, cout=0, ovf=0.
//   3. a=0xFFFF b=0x0001 cin=0 sub=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all 4 slices).
//   4. a=0x7FFF b=0x0001 sub=0 -> ovf=1, cout=0.
//      sum=0x8000 without ADDER_SAT_EN; sum=0x7FFF with it.
//   5. a=0x0005 b=0x0007 cin=0 sub=1 -> sum=0xFFFE, cout=0, ovf=0.
//      Then a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF (0x8000 with SAT), ovf=1.
//   6. Issue 8 back-to-back ops and hold out_ready=0 for 5 cycles -> in_ready drops after 4 ops are held.
//      Release -> all 8 results leave in order, one per cycle, none lost or duplicated.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// master drives operands and out_ready; slave is the adder.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub, one carry slice per stage; latency STAGES-1 edges after accept, per-stage valid/ready stalls.
// Optional ADDER_SAT_EN clamps overflowing results to the signed limit in the last stage.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_add_sub_if.slave io
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic [WIDTH-1:0]  bx;
  logic              c0;
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;

  assign bx          = io.sub ? ~io.b : io.b;
  assign c0          = io.sub ? ~io.cin : io.cin;
  assign rdy[STAGES] = io.out_ready;
  assign io.in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int HI = (k + 1) * SW;

    logic [SW-1:0] op_a;
    logic [SW-1:0] op_b;
    logic          c_in;
    logic [SW:0]   slice;
    logic [HI-1:0] s_d;
    logic          v_q;

    assign vld[k] = v_q;
    assign rdy[k] = !v_q | rdy[k+1];
    assign slice  = {1'b0, op_a} + {1'b0, op_b} + {{SW{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign op_a   = io.a[SW-1:0];
      assign op_b   = bx[SW-1:0];
      assign c_in   = c0;
      assign vin[k] = io.in_valid;
      assign s_d    = slice[SW-1:0];
    end else begin : g_src
      // Operand slice k arrives at the LSBs of what the previous stage carried forward.
      assign op_a   = g_stg[k-1].g_reg.a_q[SW-1:0];
      assign op_b   = g_stg[k-1].g_reg.b_q[SW-1:0];
      assign c_in   = g_stg[k-1].g_reg.c_q;
      assign vin[k] = vld[k-1];
      assign s_d    = {slice[SW-1:0], g_stg[k-1].g_reg.s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= vin[k];
      end
    end

    if (k < L) begin : g_reg
      logic [WIDTH-HI-1:0] a_q, b_q, a_d, b_d;
      logic [HI-1:0]       s_q;
      logic                c_q;

      if (k == 0) begin : g_rem
        assign a_d = io.a[WIDTH-1:SW];
        assign b_d = bx[WIDTH-1:SW];
      end else begin : g_rem
        assign a_d = g_stg[k-1].g_reg.a_q[WIDTH-k*SW-1:SW];
        assign b_d = g_stg[k-1].g_reg.b_q[WIDTH-k*SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (rdy[k] && vin[k]) begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= slice[SW];
        end
      end
    end
  end

  logic             msb_a;
  logic             msb_b;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign msb_a = g_stg[L].op_a[SW-1];
  assign msb_b = g_stg[L].op_b[SW-1];
  assign ovf_d = (msb_a == msb_b) & (g_stg[L].slice[SW-1] != msb_a);

`ifdef ADDER_SAT_EN
  // Overflow direction follows the sign of A: positive A can only overflow upward.
  assign res_d = ovf_d ? {msb_a, {(WIDTH-1){~msb_a}}} : g_stg[L].s_d;
`else
  assign res_d = g_stg[L].s_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (rdy[L] && vin[L]) begin
      sum_q  <= res_d;
      cout_q <= g_stg[L].slice[SW];
      ovf_q  <= ovf_d;
    end
  end

  assign io.out_valid = vld[L];
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
endmodule
